// File: rtl/ahb_si_mux_arb_pkg.sv
// AHB_package: shared AHB types for the slave-interface mux/arbiter.
// Holds the HTRANS/HBURST encodings, the address-phase payload layout and
// a helper returning the beat count of a burst type.
// The 14 control bits sit below HADDR in the payload. The top level can
// therefore decode them for any ADDR_W. AHB_ADDR_W only sizes the
// reference struct.
package AHB_package;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_e;

    localparam int AHB_CTRL_W = 14;
    localparam int AHB_ADDR_W = 32;

    typedef struct packed {
        htrans_e     htrans;
        hburst_e     hburst;
        logic [2:0]  hsize;
        logic [3:0]  hprot;
        logic        hwrite;
        logic        hmastlock;
    } ahb_ctrl_t;

    typedef struct packed {
        logic [AHB_ADDR_W-1:0] haddr;
        ahb_ctrl_t             ctrl;
    } ahb_addr_pl_t;

    // Undefined-length INCR reports 1 here.
    // Its extent is tracked separately by the incr flag.
    function automatic logic [4:0] burst_len(hburst_e b);
        case (b)
            WRAP4, INCR4:   burst_len = 5'd4;
            WRAP8, INCR8:   burst_len = 5'd8;
            WRAP16, INCR16: burst_len = 5'd16;
            default:        burst_len = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_si_mux_arb_arbiter.sv
// ahb_arbiter_rr: combinational request arbiter.
// Ports:
//   req_i   - per-master request vector
//   en_i    - arbitration allowed this cycle
//   mode_i  - 0 = fixed priority (index 0 highest), 1 = round-robin
//   ptr_i   - last round-robin winner; the search starts one past it
//   grant_o - one-hot winner (all-zero when disabled or no request)
//   idx_o   - index of the winner
//   valid_o - a winner exists
module ahb_arbiter_rr #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // The scan runs from farthest to nearest candidate, so the last hit is the winner.
    // Fixed mode visits N-1 down to 0.
    // Round-robin visits ptr+N down to ptr+1, modulo N.
    always_comb begin
        int cand;
        cand    = 0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        if (en_i) begin
            for (int k = N; k >= 1; k--) begin
                cand = mode_i ? (int'(ptr_i) + k) % N : k - 1;
                if (req_i[cand]) begin
                    valid_o = 1'b1;
                    idx_o   = IDX_W'(cand);
                end
            end
            if (valid_o) grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_si_mux_arb.sv
// ahb_si_mux_arb: registered, arbitrating master-side mux for one AHB
// slave-interface port. The address phase follows the grant register.
// The data phase follows a separate one-hot owner (dsel), so HWDATA trails
// the grant by one accepted transfer.
// Ports:
//   HCLK, HRESETn - clock and asynchronous active-low reset
//   hbusreq_i     - per-master bus request
//   addr_pl_i     - per-master address-phase payload (haddr + 14 ctrl bits)
//   hwdata_i      - per-master write data
//   hready_i      - slave ready; transfer accepted when 1
//   addr_pl_o     - granted master's payload
//   hwdata_o      - data-phase owner's write data (0 when no data phase)
//   hgrant_o      - one-hot address-phase grant
//   hmaster_o     - index of the granted master
//   dsel_o        - one-hot data-phase owner
module ahb_si_mux_arb
    import AHB_package::*;
#(
    parameter int CHANNEL_NUM = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ARB_MODE    = 1,
    localparam int PL_W       = ADDR_W + AHB_CTRL_W,
    localparam int IDX_W      = $clog2(CHANNEL_NUM)
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [CHANNEL_NUM-1:0]        hbusreq_i,
    input  logic [CHANNEL_NUM*PL_W-1:0]   addr_pl_i,
    input  logic [CHANNEL_NUM*DATA_W-1:0] hwdata_i,
    input  logic                          hready_i,
    output logic [PL_W-1:0]               addr_pl_o,
    output logic [DATA_W-1:0]             hwdata_o,
    output logic [CHANNEL_NUM-1:0]        hgrant_o,
    output logic [IDX_W-1:0]              hmaster_o,
    output logic [CHANNEL_NUM-1:0]        dsel_o
);

    logic [CHANNEL_NUM-1:0] hgrant_q, hgrant_d;
    logic [IDX_W-1:0]       hmaster_q, hmaster_d;
    logic [CHANNEL_NUM-1:0] dsel_q, dsel_d;
    logic [3:0]             rem_q, rem_d;
    logic                   incr_q, incr_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;

    ahb_ctrl_t              ownCtrl;
    logic                   isBeat;
    logic [3:0]             remUpd;
    logic                   incrUpd;
    logic                   holdOwner;
    logic [CHANNEL_NUM-1:0] arbGrant;
    logic [IDX_W-1:0]       arbIdx;
    logic                   arbValid;
    logic                   unused_ctrl;

    assign addr_pl_o   = addr_pl_i[hmaster_q*PL_W +: PL_W];
    assign ownCtrl     = ahb_ctrl_t'(addr_pl_o[AHB_CTRL_W-1:0]);
    assign unused_ctrl = ^{ownCtrl.hsize, ownCtrl.hprot, ownCtrl.hwrite};
    assign hgrant_o    = hgrant_q;
    assign hmaster_o   = hmaster_q;
    assign dsel_o      = dsel_q;

    always_comb begin
        hwdata_o = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (dsel_q[i]) hwdata_o = hwdata_o | hwdata_i[i*DATA_W +: DATA_W];
        end
    end

    // Beat bookkeeping assumes the owner's transfer is accepted.
    // The hold decision uses these post-update values. A NONSEQ that opens
    // an INCR, or leaves beats outstanding, therefore keeps the grant on
    // that same edge.
    always_comb begin
        isBeat  = (ownCtrl.htrans == NONSEQ) || (ownCtrl.htrans == SEQ);
        remUpd  = rem_q;
        incrUpd = incr_q;
        case (ownCtrl.htrans)
            NONSEQ: begin
                remUpd  = 4'(burst_len(ownCtrl.hburst) - 5'd1);
                incrUpd = (ownCtrl.hburst == INCR);
            end
            SEQ: begin
                if (rem_q != 4'd0) remUpd = rem_q - 4'd1;
            end
            IDLE: begin
                remUpd  = 4'd0;
                incrUpd = 1'b0;
            end
            default: ;
        endcase
        holdOwner = ownCtrl.hmastlock || (ownCtrl.htrans == BUSY) ||
                    (isBeat && (remUpd != 4'd0)) ||
                    (incrUpd && hbusreq_i[hmaster_q]);
    end

    ahb_arbiter_rr #(
        .N     (CHANNEL_NUM),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (hbusreq_i),
        .en_i    (hready_i && !holdOwner),
        .mode_i  (ARB_MODE != 0),
        .ptr_i   (ptr_q),
        .grant_o (arbGrant),
        .idx_o   (arbIdx),
        .valid_o (arbValid)
    );

    // Nothing moves while the slave stalls.
    // With no requester the grant parks on the current owner.
    always_comb begin
        hgrant_d  = hgrant_q;
        hmaster_d = hmaster_q;
        dsel_d    = dsel_q;
        rem_d     = rem_q;
        incr_d    = incr_q;
        ptr_d     = ptr_q;
        if (hready_i) begin
            dsel_d = isBeat ? hgrant_q : '0;
            rem_d  = remUpd;
            incr_d = incrUpd;
            if (arbValid) begin
                hgrant_d  = arbGrant;
                hmaster_d = arbIdx;
                if (ARB_MODE != 0) ptr_d = arbIdx;
                if (arbIdx != hmaster_q) begin
                    rem_d  = 4'd0;
                    incr_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hgrant_q  <= {{(CHANNEL_NUM-1){1'b0}}, 1'b1};
            hmaster_q <= '0;
            dsel_q    <= '0;
            rem_q     <= 4'd0;
            incr_q    <= 1'b0;
            ptr_q     <= '0;
        end else begin
            hgrant_q  <= hgrant_d;
            hmaster_q <= hmaster_d;
            dsel_q    <= dsel_d;
            rem_q     <= rem_d;
            incr_q    <= incr_d;
            ptr_q     <= ptr_d;
        end
    end

endmodule

// File: tb/tb_ahb_si_mux_arb.sv
// Bench for ahb_si_mux_arb.
// It drives a 2-master round-robin instance and a 4-master fixed-priority
// instance side by side. Expected outputs come from a transaction-level
// model: who owns the bus, who owns the data phase, how many beats remain,
// and whether an undefined INCR is running.
module tb_ahb_si_mux_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PW = AW + 14;

    logic HCLK = 1'b0;
    logic HRESETn;
    logic hready;

    // Free-running clock, 10 time units per cycle
    always #5 HCLK = ~HCLK;

    logic [1:0]    req2;
    logic [1:0]    tr2 [2];
    logic [2:0]    bu2 [2];
    logic          lk2 [2];
    logic [AW-1:0] ad2 [2];
    logic [DW-1:0] wd2 [2];
    logic [2*PW-1:0] pl2;
    logic [2*DW-1:0] wdv2;
    logic [PW-1:0] plO2;
    logic [DW-1:0] wdO2;
    logic [1:0]    gnt2;
    logic          hm2;
    logic [1:0]    ds2;

    logic [3:0]    req4;
    logic [1:0]    tr4 [4];
    logic [2:0]    bu4 [4];
    logic          lk4 [4];
    logic [AW-1:0] ad4 [4];
    logic [DW-1:0] wd4 [4];
    logic [4*PW-1:0] pl4;
    logic [4*DW-1:0] wdv4;
    logic [PW-1:0] plO4;
    logic [DW-1:0] wdO4;
    logic [3:0]    gnt4;
    logic [1:0]    hm4;
    logic [3:0]    ds4;

    int total = 0;
    int bad   = 0;

    // Payload layout: haddr, htrans, hburst, hsize=word, hprot, hwrite, hmastlock
    function automatic logic [PW-1:0] plOf2(int i);
        return {ad2[i], tr2[i], bu2[i], 3'b010, 4'b0011, 1'b1, lk2[i]};
    endfunction

    function automatic logic [PW-1:0] plOf4(int i);
        return {ad4[i], tr4[i], bu4[i], 3'b010, 4'b0011, 1'b1, lk4[i]};
    endfunction

    // Packs the per-master views into the flat vectors the DUTs take
    always_comb begin
        pl2 = '0; wdv2 = '0; pl4 = '0; wdv4 = '0;
        for (int i = 0; i < 2; i++) begin
            pl2[i*PW +: PW]  = plOf2(i);
            wdv2[i*DW +: DW] = wd2[i];
        end
        for (int i = 0; i < 4; i++) begin
            pl4[i*PW +: PW]  = plOf4(i);
            wdv4[i*DW +: DW] = wd4[i];
        end
    end

    ahb_si_mux_arb #(.CHANNEL_NUM(2), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .hbusreq_i(req2), .addr_pl_i(pl2),
        .hwdata_i(wdv2), .hready_i(hready), .addr_pl_o(plO2), .hwdata_o(wdO2),
        .hgrant_o(gnt2), .hmaster_o(hm2), .dsel_o(ds2)
    );

    ahb_si_mux_arb #(.CHANNEL_NUM(4), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) dutFp (
        .HCLK(HCLK), .HRESETn(HRESETn), .hbusreq_i(req4), .addr_pl_i(pl4),
        .hwdata_i(wdv4), .hready_i(hready), .addr_pl_o(plO4), .hwdata_o(wdO4),
        .hgrant_o(gnt4), .hmaster_o(hm4), .dsel_o(ds4)
    );

    // Bus-level view: owner, data-phase owner (-1 = none), beats still
    // expected after the last accepted one, undefined-INCR flag, RR pointer
    typedef struct packed {
        int owner;
        int dOwner;
        int left;
        bit incr;
        int ptr;
    } mstate_t;

    mstate_t m2, m4;

    function automatic mstate_t rstState();
        mstate_t s;
        s.owner = 0; s.dOwner = -1; s.left = 0; s.incr = 1'b0; s.ptr = 0;
        return s;
    endfunction

    function automatic int beatsOf(int b);
        case (b)
            2, 3:    return 4;
            4, 5:    return 8;
            6, 7:    return 16;
            default: return 1;
        endcase
    endfunction

    // One accepted transfer by the owner, followed by the arbitration decision
    function automatic mstate_t stepModel(mstate_t s, int n, int mode, int reqMask,
                                          int tr, int bu, bit lk);
        mstate_t r;
        bit beat, keep;
        int win, c;
        r = s;
        beat = (tr == 2) || (tr == 3);
        r.dOwner = beat ? s.owner : -1;
        if (tr == 2) begin
            r.left = beatsOf(bu) - 1;
            r.incr = (bu == 1);
        end else if (tr == 3) begin
            if (r.left > 0) r.left = r.left - 1;
        end else if (tr == 0) begin
            r.left = 0;
            r.incr = 1'b0;
        end
        keep = lk || (tr == 1) || (beat && r.left > 0) || (r.incr && reqMask[s.owner]);
        if (!keep && reqMask != 0) begin
            win = -1;
            for (int k = 0; k < n; k++) begin
                c = (mode == 0) ? k : (s.ptr + 1 + k) % n;
                if (win < 0 && reqMask[c]) win = c;
            end
            if (win != s.owner) begin
                r.left = 0;
                r.incr = 1'b0;
            end
            r.owner = win;
            if (mode != 0) r.ptr = win;
        end
        return r;
    endfunction

    // Advances both DUTs and models by one clock. Checks happen #1 after the edge.
    task automatic tick();
        mstate_t n2, n4;
        n2 = m2;
        n4 = m4;
        if (!HRESETn) begin
            n2 = rstState();
            n4 = rstState();
        end else if (hready) begin
            n2 = stepModel(m2, 2, 1, int'(req2), int'(tr2[m2.owner]), int'(bu2[m2.owner]), lk2[m2.owner]);
            n4 = stepModel(m4, 4, 0, int'(req4), int'(tr4[m4.owner]), int'(bu4[m4.owner]), lk4[m4.owner]);
        end
        @(posedge HCLK);
        m2 = n2;
        m4 = n4;
        #1;
    endtask

    task automatic clearInputs();
        hready = 1'b1;
        req2 = '0;
        req4 = '0;
        for (int i = 0; i < 2; i++) begin
            tr2[i] = 2'd0; bu2[i] = 3'd0; lk2[i] = 1'b0; ad2[i] = $urandom; wd2[i] = $urandom;
        end
        for (int i = 0; i < 4; i++) begin
            tr4[i] = 2'd0; bu4[i] = 3'd0; lk4[i] = 1'b0; ad4[i] = $urandom; wd4[i] = $urandom;
        end
    endtask

    task automatic randomInputs();
        hready = ($urandom_range(0, 3) != 0);
        req2 = 2'($urandom);
        req4 = 4'($urandom);
        for (int i = 0; i < 2; i++) begin
            tr2[i] = 2'($urandom); bu2[i] = 3'($urandom); lk2[i] = ($urandom_range(0, 9) == 0);
            ad2[i] = $urandom; wd2[i] = $urandom;
        end
        for (int i = 0; i < 4; i++) begin
            tr4[i] = 2'($urandom); bu4[i] = 3'($urandom); lk4[i] = ($urandom_range(0, 9) == 0);
            ad4[i] = $urandom; wd4[i] = $urandom;
        end
    endtask

    task automatic applyReset();
        HRESETn = 1'b0;
        clearInputs();
        tick();
        tick();
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        randomInputs();
        tick();
        for (int c = 0; c < 3; c++) begin
            randomInputs();
            #2;
            total++;
            if (gnt2 !== 2'b01 || ds2 !== 2'b00 || wdO2 !== '0 || hm2 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset2 gnt=%b ds=%b wd=%h hm=%0d want gnt=01 ds=00 wd=0 hm=0", gnt2, ds2, wdO2, hm2);
            end
            total++;
            if (gnt4 !== 4'b0001 || ds4 !== 4'b0000 || wdO4 !== '0) begin
                bad++;
                $display("[TB] FAIL reset4 gnt=%b ds=%b wd=%h want gnt=0001 ds=0000 wd=0", gnt4, ds4, wdO4);
            end
            tick();
        end
        HRESETn = 1'b1;
        clearInputs();
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (gnt2 !== 2'b01 || ds2 !== 2'b00) begin
                bad++;
                $display("[TB] FAIL park cyc%0d gnt=%b ds=%b want gnt=01 ds=00", c, gnt2, ds2);
            end
        end
    endtask

    task automatic test_rr_contention();
        logic [1:0] wantG, prevG;
        int prevOwner;
        applyReset();
        req2 = 2'b11;
        tr2[0] = 2'd2; tr2[1] = 2'd2;
        for (int c = 0; c < 6; c++) begin
            wd2[0] = $urandom; wd2[1] = $urandom;
            prevOwner = m2.owner;
            prevG = 2'(1 << prevOwner);
            tick();
            wantG = (c % 2 == 0) ? 2'b10 : 2'b01;
            total++;
            if (gnt2 !== wantG || int'(hm2) != m2.owner) begin
                bad++;
                $display("[TB] FAIL rr_grant cyc%0d gnt=%b hm=%0d want gnt=%b hm=%0d", c, gnt2, hm2, wantG, m2.owner);
            end
            total++;
            if (ds2 !== prevG || wdO2 !== wd2[prevOwner]) begin
                bad++;
                $display("[TB] FAIL rr_data cyc%0d ds=%b wd=%h want ds=%b wd=%h", c, ds2, wdO2, prevG, wd2[prevOwner]);
            end
        end
    endtask

    task automatic test_burst_hold();
        int trSeq [4] = '{2, 3, 3, 3};
        logic [1:0] wantG;
        applyReset();
        req2 = 2'b01;
        tr2[1] = 2'd2;
        bu2[0] = 3'd3;
        for (int c = 0; c < 4; c++) begin
            tr2[0] = 2'(trSeq[c]);
            tick();
            req2 = 2'b11;
            wantG = (c < 3) ? 2'b01 : 2'b10;
            total++;
            if (gnt2 !== wantG || ds2 !== 2'b01) begin
                bad++;
                $display("[TB] FAIL burst_hold beat%0d gnt=%b ds=%b want gnt=%b ds=01", c, gnt2, ds2, wantG);
            end
        end
    endtask

    task automatic test_stall();
        int trSeq [7]  = '{2, 3, 3, 3, 3, 3, 3};
        int rdySeq [7] = '{1, 1, 0, 0, 0, 1, 1};
        int accepted = 0;
        logic [1:0] wantG;
        applyReset();
        req2 = 2'b11;
        tr2[1] = 2'd2;
        bu2[0] = 3'd3;
        for (int c = 0; c < 7; c++) begin
            tr2[0] = 2'(trSeq[c]);
            hready = rdySeq[c][0];
            if (rdySeq[c] != 0) accepted++;
            tick();
            wantG = (accepted < 4) ? 2'b01 : 2'b10;
            total++;
            if (gnt2 !== wantG || ds2 !== 2'b01 || gnt2 !== 2'(1 << m2.owner)) begin
                bad++;
                $display("[TB] FAIL stall cyc%0d gnt=%b ds=%b want gnt=%b ds=01", c, gnt2, ds2, wantG);
            end
        end
        hready = 1'b1;
    endtask

    task automatic test_lock_incr();
        int trSeq [6] = '{2, 2, 2, 3, 3, 3};
        int buSeq [6] = '{0, 0, 1, 1, 1, 1};
        int lkSeq [6] = '{1, 1, 0, 0, 0, 0};
        int rqSeq [6] = '{1, 1, 1, 1, 1, 0};
        logic [1:0] wantG;
        applyReset();
        req2 = 2'b10;
        tick();
        total++;
        if (gnt2 !== 2'b10) begin
            bad++;
            $display("[TB] FAIL lock_takeover gnt=%b want=10", gnt2);
        end
        tr2[0] = 2'd2;
        for (int c = 0; c < 6; c++) begin
            tr2[1] = 2'(trSeq[c]);
            bu2[1] = 3'(buSeq[c]);
            lk2[1] = lkSeq[c][0];
            req2   = {rqSeq[c][0], 1'b1};
            tick();
            wantG = (c < 5) ? 2'b10 : 2'b01;
            total++;
            if (gnt2 !== wantG || ds2 !== 2'b10) begin
                bad++;
                $display("[TB] FAIL lock_incr cyc%0d gnt=%b ds=%b want gnt=%b ds=10", c, gnt2, ds2, wantG);
            end
        end
    endtask

    task automatic test_fixed_prio();
        applyReset();
        req4 = 4'b1100;
        tr4[2] = 2'd2; tr4[3] = 2'd2;
        tick();
        total++;
        if (gnt4 !== 4'b0100 || hm4 !== 2'd2) begin
            bad++;
            $display("[TB] FAIL fixed_first gnt=%b hm=%0d want gnt=0100 hm=2", gnt4, hm4);
        end
        req4 = 4'b1110;
        tr4[1] = 2'd2;
        tick();
        total++;
        if (gnt4 !== 4'b0010 || hm4 !== 2'd1 || ds4 !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL fixed_second gnt=%b hm=%0d ds=%b want gnt=0010 hm=1 ds=0100", gnt4, hm4, ds4);
        end
    endtask

    task automatic test_reset_mid_burst();
        applyReset();
        req2 = 2'b11;
        tr2[1] = 2'd2;
        tr2[0] = 2'd2; bu2[0] = 3'd7;
        tick();
        tr2[0] = 2'd3;
        tick();
        tick();
        #2;
        HRESETn = 1'b0;
        m2 = rstState();
        m4 = rstState();
        #1;
        total++;
        if (gnt2 !== 2'b01 || ds2 !== 2'b00 || wdO2 !== '0) begin
            bad++;
            $display("[TB] FAIL midburst_reset gnt=%b ds=%b wd=%h want gnt=01 ds=00 wd=0", gnt2, ds2, wdO2);
        end
        tick();
        HRESETn = 1'b1;
        tr2[0] = 2'd2; bu2[0] = 3'd0;
        tick();
        total++;
        if (gnt2 !== 2'b10 || ds2 !== 2'b01) begin
            bad++;
            $display("[TB] FAIL after_reset gnt=%b ds=%b want gnt=10 ds=01", gnt2, ds2);
        end
    endtask

    task automatic test_random();
        logic [1:0] eg2, ed2;
        logic [3:0] eg4, ed4;
        logic [DW-1:0] ew2, ew4;
        applyReset();
        for (int c = 0; c < 400; c++) begin
            randomInputs();
            tick();
            eg2 = 2'(1 << m2.owner);
            ed2 = (m2.dOwner < 0) ? 2'b00 : 2'(1 << m2.dOwner);
            ew2 = (m2.dOwner < 0) ? '0 : wd2[m2.dOwner];
            eg4 = 4'(1 << m4.owner);
            ed4 = (m4.dOwner < 0) ? 4'b0000 : 4'(1 << m4.dOwner);
            ew4 = (m4.dOwner < 0) ? '0 : wd4[m4.dOwner];
            total++;
            if (gnt2 !== eg2 || int'(hm2) != m2.owner || ds2 !== ed2 || wdO2 !== ew2 || plO2 !== plOf2(m2.owner)) begin
                bad++;
                $display("[TB] FAIL rand2 cyc%0d gnt=%b ds=%b wd=%h pl=%h want gnt=%b ds=%b wd=%h pl=%h",
                         c, gnt2, ds2, wdO2, plO2, eg2, ed2, ew2, plOf2(m2.owner));
            end
            total++;
            if (gnt4 !== eg4 || int'(hm4) != m4.owner || ds4 !== ed4 || wdO4 !== ew4 || plO4 !== plOf4(m4.owner)) begin
                bad++;
                $display("[TB] FAIL rand4 cyc%0d gnt=%b ds=%b wd=%h pl=%h want gnt=%b ds=%b wd=%h pl=%h",
                         c, gnt4, ds4, wdO4, plO4, eg4, ed4, ew4, plOf4(m4.owner));
            end
        end
    endtask

    // Scenario sequence. Every task starts from its own reset, except the first.
    initial begin
        m2 = rstState();
        m4 = rstState();
        clearInputs();
        test_reset();
        test_rr_contention();
        test_burst_hold();
        test_stall();
        test_lock_incr();
        test_fixed_prio();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_si_mux_arb.md
Name: ahb_si_mux_arb

Overview:
- Registered, arbitrating master-side multiplexer for one AHB slave-interface port.
- Parametrised successor of the combinational master payload mux.
- Arbitrates among CHANNEL_NUM masters (fixed-priority or round-robin) and holds the grant for whole bursts and locked sequences.
- Splits the master payload into address-phase and data-phase paths, each with its own select, so HWDATA follows the previous owner while the new owner drives the address phase.

Parameters:
- CHANNEL_NUM, 2, number of master channels (2..16).
- ADDR_W, 32, HADDR width.
- DATA_W, 32, HWDATA width.
- ARB_MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- hbusreq_i  in  CHANNEL_NUM  per-master bus request.
- addr_pl_i  in  CHANNEL_NUM x (ADDR_W+14)  per-master address-phase payload, packed per ahb_addr_pl_t.
- hwdata_i  in  CHANNEL_NUM x DATA_W  per-master write data.
- hready_i  in  1  slave HREADY; transfer accepted when 1.
- addr_pl_o  out  ADDR_W+14  selected address-phase payload.
- hwdata_o  out  DATA_W  selected data-phase write data.
- hgrant_o  out  CHANNEL_NUM  one-hot address-phase grant.
- hmaster_o  out  $clog2(CHANNEL_NUM)  index of the granted master.
- dsel_o  out  CHANNEL_NUM  one-hot data-phase owner; all-zero when no data phase is active.

Behaviour:
- Clock and reset: one clock, HCLK. Reset HRESETn is asynchronous, active-low.
- Reset values: hgrant_o = 'b1 (park on channel 0); hmaster_o = 0; dsel_o = 0; hwdata_o = 0; beat counter = 0; incr flag = 0; round-robin pointer = 0.
- Address mux: addr_pl_o = addr_pl_i[hmaster] combinationally from the grant register. Zero extra latency.
- Data mux: on each edge with hready_i = 1, dsel <= hgrant if the owner's HTRANS is NONSEQ or SEQ, else dsel <= 0. hwdata_o = hwdata_i[dsel], or 0 when dsel = 0.
- hready_i = 0: grant, dsel, counter and flag all hold.
- Beat tracking, on an accepted owner NONSEQ:
  - rem <= burst length - 1 (SINGLE 0; INCR4/WRAP4 3; INCR8/WRAP8 7; INCR16/WRAP16 15).
  - incr <= (HBURST == INCR).
- Beat tracking, on an accepted SEQ: rem decrements if nonzero. Accepted IDLE clears incr and rem.
- Re-arbitration happens only on an edge with hready_i = 1 and none of the hold conditions true. Hold conditions:
  - owner HMASTLOCK = 1;
  - owner HTRANS = BUSY;
  - owner accepted a beat leaving rem > 0 after update;
  - incr = 1 and owner hbusreq_i = 1.
- Arbitration result:
  - ARB_MODE 0: lowest-index requester wins.
  - ARB_MODE 1: search starts at pointer+1 modulo CHANNEL_NUM; the pointer updates to the winner.
  - No requester: the grant stays parked on the current owner.
  - A new owner clears rem and incr.
- Simultaneous requests are resolved by the mode. The current owner may win again.
- Reset mid-burst: immediate return to the reset values. The burst is abandoned with no cleanup.
- SEQ from a non-owner is never observed, because only the owner's payload is decoded.

Decomposition:
- Package AHB_package holds:
  - ahb_addr_pl_t packed struct: haddr[ADDR_W], htrans[2], hburst[3], hsize[3], hprot[4], hwrite, hmastlock;
  - htrans_e {IDLE, BUSY, NONSEQ, SEQ};
  - hburst_e;
  - function burst_len(hburst_e).
- One sub-module: ahb_arbiter_rr (request vector, enable, mode, pointer -> one-hot grant). The mux datapaths stay in the top level.

Test Plan:
- Reset: HRESETn low with random inputs -> hgrant_o = 01, dsel_o = 00, hwdata_o = 0. Release, no requests -> grant stays 01.
- RR contention: ARB_MODE 1, both masters request SINGLE NONSEQ every cycle, hready_i = 1 -> hgrant_o alternates 01, 10, 01. dsel_o trails the grant by one cycle. hwdata_o = the previous owner's data.
- Burst hold: master 0 INCR4 (NONSEQ + 3 SEQ), master 1 requesting from cycle 1 -> grant stays 01 for 4 accepted beats. Grant becomes 10 on the edge accepting the 4th beat.
- Stall: insert hready_i = 0 for 3 cycles mid-INCR4 -> grant, dsel and the beat count freeze. The burst completes with exactly 4 accepted beats.
- Lock and INCR: master 1 HMASTLOCK = 1 across two SINGLEs, then an undefined INCR with hbusreq held -> no switch to master 0. Switch occurs one edge after hbusreq_i[1] drops with hready_i = 1.
- Fixed priority: ARB_MODE 0, CHANNEL_NUM 4, requests 1100 then 1110 -> grants 0100 then 0010 at the next arbitration points. hmaster_o = 2, then 1.
